// File: rtl/lsu_seq.sv
// ============================================================================
// Module   : lsu_seq
// Purpose  : Load/store sequencer between the multicycle control unit and data memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_seq #(
  parameter int XLEN    = 64,
  parameter int MEM_LAT = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            is_store_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misalign_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_wr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int         OFFW    = $clog2(XLEN / 8);
  localparam int         CW      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [1:0] FULL_SZ = (XLEN == 64) ? 2'd3 : 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            store_q, store_d;
  logic [2:0]      f3_q, f3_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            misalign_q, misalign_d;
  logic            illegal_q, illegal_d;

  function automatic logic [XLEN-1:0] lane_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    lane_mask = XLEN'(8'hFF);
      2'd1:    lane_mask = XLEN'(16'hFFFF);
      2'd2:    lane_mask = XLEN'(32'hFFFF_FFFF);
      default: lane_mask = '1;
    endcase
  endfunction

  // Request decode; illegal wins so the two flags are mutually exclusive.
  logic req_illegal, req_misalign;
  always_comb begin
    req_illegal = (funct3_i == 3'b111) || (is_store_i && funct3_i[2]) ||
                  ((XLEN == 32) && ((funct3_i == 3'b011) || (funct3_i == 3'b110)));
    case (funct3_i[1:0])
      2'd1:    req_misalign = addr_i[0];
      2'd2:    req_misalign = (addr_i[1:0] != 2'b00);
      2'd3:    req_misalign = (addr_i[2:0] != 3'b000);
      default: req_misalign = 1'b0;
    endcase
    req_misalign = req_misalign && !req_illegal;
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  logic [OFFW+2:0] sh_amt;
  logic [XLEN-1:0] lmask, rd_shifted, ld_ext, st_merged;
  logic            sign_bit;
  always_comb begin
    sh_amt     = {off_q, 3'b000};
    lmask      = lane_mask(f3_q[1:0]);
    rd_shifted = mem_rdata_i >> sh_amt;
    case (f3_q[1:0])
      2'd0:    sign_bit = rd_shifted[7];
      2'd1:    sign_bit = rd_shifted[15];
      2'd2:    sign_bit = rd_shifted[31];
      default: sign_bit = 1'b0;
    endcase
    sign_bit  = sign_bit && !f3_q[2];
    ld_ext    = (rd_shifted & lmask) | (sign_bit ? ~lmask : '0);
    st_merged = (mem_rdata_i & ~(lmask << sh_amt)) | ((wdata_q & lmask) << sh_amt);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    f3_d        = f3_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;
    misalign_d  = misalign_q;
    illegal_d   = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          store_d    = is_store_i;
          f3_d       = funct3_i;
          off_d      = addr_i[OFFW-1:0];
          mem_addr_d = addr_i & ~XLEN'(XLEN / 8 - 1);
          wdata_d    = wdata_i;
          illegal_d  = req_illegal;
          misalign_d = req_misalign;
          cnt_d      = '0;
          if (req_illegal || req_misalign) begin
            state_d = S_DONE;
          end else if (is_store_i && (funct3_i[1:0] == FULL_SZ)) begin
            mem_wdata_d = wdata_i;
            state_d     = S_WRITE;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == CW'(MEM_LAT - 1)) begin
          cnt_d = '0;
          if (store_q) begin
            mem_wdata_d = st_merged;
            state_d     = S_WRITE;
          end else begin
            rdata_d = ld_ext;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= '0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      misalign_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
      misalign_q  <= misalign_d;
      illegal_q   <= illegal_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign mem_wr_o    = (state_q == S_WRITE);
  assign misalign_o  = misalign_q && (state_q == S_DONE);
  assign illegal_o   = illegal_q && (state_q == S_DONE);
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_seq.sv
// ============================================================================
// Module   : tb_lsu_seq
// Purpose  : Directed and random checks of lsu_seq against a byte-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_seq;

  localparam int XLEN = 64;
  localparam int LAT  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [63:0] mem_rdata = '0;
  logic        busy, done, misalign, illegal, mem_wr;
  logic [63:0] rdata, mem_addr, mem_wdata;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] rdata_model = '0;

  lsu_seq #(.XLEN(XLEN), .MEM_LAT(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .is_store_i(is_store),
    .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .rdata_o(rdata),
    .misalign_o(misalign), .illegal_o(illegal),
    .mem_addr_o(mem_addr), .mem_wr_o(mem_wr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Little-endian byte view of the memory word.
  function automatic logic [63:0] ref_load(input logic [63:0] word, input logic [63:0] a,
                                           input logic [2:0] f3);
    int n = 1 << f3[1:0];
    int off = int'(a[2:0]);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) v[8*i +: 8] = word[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [63:0] ref_store(input logic [63:0] word, input logic [63:0] a,
                                            input logic [2:0] f3, input logic [63:0] wd);
    int n = 1 << f3[1:0];
    int off = int'(a[2:0]);
    logic [63:0] v = word;
    if (n == 8) return wd;
    for (int i = 0; i < n; i++)
      if (off + i < 8) v[8*(off+i) +: 8] = wd[8*i +: 8];
    return v;
  endfunction

  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] word, input string tag);
    int n = 1 << f3[1:0];
    logic ill, mis;
    int exp_done, exp_wr;
    int done_at = 0, wr_at = 0, wr_cnt = 0, busy_bad = 0, post_bad = 0;
    logic [63:0] wr_data = '0, ma = '0;
    logic mis_seen = 1'b0, ill_seen = 1'b0;
    ill = (f3 == 3'b111) || (st && f3[2]);
    mis = !ill && ((a % 64'(n)) != 0);
    exp_done = (ill || mis) ? 1 : (!st ? LAT + 1 : ((n == 8) ? 2 : LAT + 2));
    exp_wr   = (ill || mis || !st) ? 0 : ((n == 8) ? 1 : LAT + 1);
    mem_rdata = word;
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    for (int c = 1; c <= 12 && done_at == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Garbage request while busy: must be ignored.
        start = 1'b1; is_store = 1'($urandom); funct3 = 3'($urandom);
        addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      if (busy !== 1'b1) busy_bad++;
      if (mem_wr === 1'b1) begin wr_cnt++; wr_at = c; wr_data = mem_wdata; end
      if (done === 1'b1) begin
        done_at = c; mis_seen = misalign; ill_seen = illegal; ma = mem_addr;
      end
    end
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || mem_wr !== 1'b0) post_bad++;
    end
    if (!st && !ill && !mis) rdata_model = ref_load(word, a, f3);
    chk({tag, " done_cycle"}, 64'(done_at), 64'(exp_done));
    chk({tag, " wr_count"}, 64'(wr_cnt), (exp_wr != 0) ? 64'd1 : 64'd0);
    if (exp_wr != 0) begin
      chk({tag, " wr_cycle"}, 64'(wr_at), 64'(exp_wr));
      chk({tag, " mem_wdata"}, wr_data, ref_store(word, a, f3, wd));
    end
    chk({tag, " misalign"}, 64'(mis_seen), 64'(mis));
    chk({tag, " illegal"}, 64'(ill_seen), 64'(ill));
    if (!ill && !mis) chk({tag, " mem_addr"}, ma, a & ~64'd7);
    chk({tag, " busy_gaps"}, 64'(busy_bad), 64'd0);
    chk({tag, " idle_after"}, 64'(post_bad), 64'd0);
    chk({tag, " rdata"}, rdata, rdata_model);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " misalign"}, 64'(misalign), 64'd0);
    chk({tag, " illegal"}, 64'(illegal), 64'd0);
    chk({tag, " mem_wr"}, 64'(mem_wr), 64'd0);
    chk({tag, " rdata"}, rdata, 64'd0);
    chk({tag, " mem_addr"}, mem_addr, 64'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 64'd0);
  endtask

  initial begin
    logic found;
    logic [63:0] ra;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    run_txn(1'b0, 3'b001, 64'h1006, 64'h0, 64'h8001_0000_0000_0000, "load_h");
    chk("load_h literal", rdata, 64'hFFFF_FFFF_FFFF_8001);
    run_txn(1'b0, 3'b101, 64'h1006, 64'h0, 64'h8001_0000_0000_0000, "load_hu");
    chk("load_hu literal", rdata, 64'h0000_0000_0000_8001);
    run_txn(1'b1, 3'b000, 64'h2003, 64'hAB, 64'h1111_1111_1111_1111, "store_b");
    run_txn(1'b1, 3'b011, 64'h3008, 64'hDEAD_BEEF_0123_4567, 64'h5555_5555_5555_5555, "store_d");
    run_txn(1'b0, 3'b010, 64'h4002, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, "load_w_mis");
    chk("load_w_mis keeps rdata", rdata, 64'h0000_0000_0000_8001);
    run_txn(1'b0, 3'b111, 64'h4000, 64'h0, 64'h0, "f3_111");
    run_txn(1'b1, 3'b100, 64'h4000, 64'h0, 64'h0, "store_bu");
    run_txn(1'b0, 3'b000, 64'h5007, 64'h0, 64'h80FF_FFFF_FFFF_FFFF, "load_b_top");
    run_txn(1'b0, 3'b110, 64'h5004, 64'h0, 64'hCAFE_F00D_0000_0000, "load_wu_hi");
    run_txn(1'b1, 3'b001, 64'h6006, 64'h1234_5678_9ABC_DEF0, 64'hAAAA_BBBB_CCCC_DDDD, "store_h_top");

    for (int i = 0; i < 40; i++) begin
      ra = {32'h0, $urandom};
      if ($urandom_range(0, 1) == 0) ra[2:0] = 3'b000;
      run_txn(1'($urandom), 3'($urandom), ra, {$urandom, $urandom}, {$urandom, $urandom}, "rand");
    end

    // Asynchronous reset in the middle of a sub-word store's WRITE cycle.
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 64'h7005; wdata = 64'h5A;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (mem_wr === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    chk("rst_mid write_seen", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    rdata_model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 3'b011, 64'h8000, 64'h0, 64'hFEDC_BA98_7654_3210, "load_d_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
